calc1_port_driver: RTL and testbench
====================================

Name: calc1_port_driver

Overview:
- Initiator for one calc1 request/response port: the requester end that calc1_top answers.
- Accepts a job (command, operand1, operand2) over a valid/ready handshake.
- Drives the two-cycle calc1 request sequence, waits for the response with a timeout, and checks it against an internal reference model.
- Returns the result upstream. Four instances, one per calc1 port, form the self-checking stimulus layer around the calculator.

Parameters:
- TIMEOUT, 255: max c_clk cycles in WAIT before the job completes as timed out (1..65535).
- ERR_CNT_W, 16: width of the saturating error counter.

Ports:
- c_clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- job_valid  input  1  upstream job offered.
- job_ready  output  1  driver idle, can accept a job.
- job_cmd  input  4  calc1 command: 0 no-op, 1 add, 2 sub, 5 shl, 6 shr, others invalid.
- job_op1  input  32  operand 1.
- job_op2  input  32  operand 2.
- req_cmd_out  output  4  to calc1 reqN_cmd_in.
- req_data_out  output  32  to calc1 reqN_data_in.
- out_resp  input  2  from calc1: 0 none, 1 ok, 2 overflow/underflow, 3 invalid.
- out_data  input  32  from calc1 result.
- done_valid  output  1  result available.
- done_ready  input  1  upstream accepts result.
- done_resp  output  2  captured response (0 on no-op or timeout).
- done_data  output  32  captured out_data.
- done_timeout  output  1  job ended by timeout.
- done_mismatch  output  1  response or data differs from the model.
- protocol_err  output  1  sticky: out_resp nonzero outside WAIT.
- err_count  output  ERR_CNT_W  saturating count of jobs with timeout or mismatch.

Behaviour:
- Reset (async, reset=0): state IDLE.
  - All outputs 0 except job_ready=1.
  - Any in-flight job is dropped; protocol_err and err_count cleared.
- States: IDLE -> CMD -> OPND2 -> WAIT -> DONE -> IDLE. A no-op job goes OPND2 -> DONE.
- IDLE:
  - job_ready=1; req_cmd_out=0, req_data_out=0.
  - On job_valid & job_ready, latch cmd/op1/op2 and go to CMD.
- CMD (1 cycle): req_cmd_out=latched cmd, req_data_out=op1.
- OPND2 (1 cycle): req_cmd_out=0, req_data_out=op2.
  - Next state is DONE if cmd=0, otherwise WAIT with the wait counter cleared.
- WAIT:
  - req_cmd_out=0, req_data_out=0; the counter increments each cycle.
  - First cycle with out_resp!=0: capture out_resp and out_data, go to DONE.
  - If the counter reaches TIMEOUT with no response: done_timeout=1, done_resp=0, done_data=0, go to DONE.
  - A response arriving in the same cycle as the counter reaches TIMEOUT wins; no timeout is flagged.
- Reference model (computed at latch time, unsigned 32-bit):
  - add: op1+op2; carry out means expected resp 2.
  - sub: op1-op2; op2>op1 means resp 2.
  - shl: op1 << op2[4:0]; shr: op1 >> op2[4:0]; both resp 1.
  - Invalid cmd: resp 3. No-op: resp 0.
- Mismatch check:
  - done_mismatch=1 if the captured resp differs from the expected resp.
  - Or if resp=1 and data differs from the expected data.
  - Data is not compared for resp 2/3.
  - A timeout never sets done_mismatch.
- DONE:
  - done_valid=1; done_* fields are stable until done_valid & done_ready.
  - On that handshake: return to IDLE, clear done_*, and increment err_count (saturating at all-ones) if timeout|mismatch.
  - job_ready stays 0 until IDLE is re-entered; back-to-back jobs therefore have at least one idle cycle.
- protocol_err is set sticky on out_resp!=0 in IDLE, CMD, OPND2 or DONE. That response is otherwise ignored.
- Only one job is outstanding at a time; calc1 ports are single-outstanding.

Test Plan:
- Add 0x0000_0001+0x0000_0002 with response 1/0x3 after 3 cycles -> CMD cycle shows cmd=1,data=1; next cycle cmd=0,data=2; done_resp=1, done_data=3, mismatch=0.
- Add 0xFFFF_FFFF+1 with response 2 -> done_resp=2, mismatch=0. Same job with response 1/0x0 -> mismatch=1, err_count=1.
- Sub 5-7 answered 2 -> mismatch=0. Shl 0x1 by 0x21 answered 1/0x2 -> mismatch=0 (shift uses op2[4:0]=1).
- Cmd 0xF answered 3 -> mismatch=0. Cmd 0 -> DONE directly after OPND2, done_resp=0, no WAIT.
- TIMEOUT=4, no response -> done_timeout=1 after 4 WAIT cycles, err_count increments. done_ready held low for 10 cycles -> outputs stable.
- Reset low during WAIT -> next cycle job_ready=1, outputs 0. out_resp=1 asserted in IDLE -> protocol_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/calc1_port_driver.sv
// calc1_port_driver: requester end of one calc1 port. Takes a job over valid/ready, drives the
// two-cycle calc1 request, waits (bounded) for the response, checks it against a reference model
// computed at accept time, and hands the captured result back upstream.
module calc1_port_driver #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 c_clk,
  input  logic                 reset,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [3:0]           job_cmd,
  input  logic [31:0]          job_op1,
  input  logic [31:0]          job_op2,
  output logic [3:0]           req_cmd_out,
  output logic [31:0]          req_data_out,
  input  logic [1:0]           out_resp,
  input  logic [31:0]          out_data,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [1:0]           done_resp,
  output logic [31:0]          done_data,
  output logic                 done_timeout,
  output logic                 done_mismatch,
  output logic                 protocol_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {StIdle, StCmd, StOpnd2, StWait, StDone} state_e;

  // Counter value on the last permitted WAIT cycle.
  localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic [3:0]           cmd_q, cmd_d;
  logic [31:0]          op1_q, op1_d;
  logic [31:0]          op2_q, op2_d;
  logic [1:0]           exp_resp_q, exp_resp_d;
  logic [31:0]          exp_data_q, exp_data_d;
  logic [15:0]          wait_cnt_q, wait_cnt_d;
  logic [1:0]           resp_q, resp_d;
  logic [31:0]          data_q, data_d;
  logic                 timeout_q, timeout_d;
  logic                 mismatch_q, mismatch_d;
  logic                 proto_q, proto_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  logic        resp_seen;
  logic        wait_hit;
  logic        accept;
  logic        release_done;
  logic [32:0] add_full;
  logic [1:0]  model_resp;
  logic [31:0] model_data;

  assign resp_seen    = (out_resp != 2'd0);
  assign wait_hit     = (wait_cnt_q == WaitLast);
  assign accept       = (state_q == StIdle) && job_valid;
  assign release_done = (state_q == StDone) && done_ready;
  assign add_full     = {1'b0, job_op1} + {1'b0, job_op2};

  // Reference model evaluated on the job inputs so it can be latched on accept.
  always_comb begin
    model_resp = 2'd3;
    model_data = 32'd0;
    unique case (job_cmd)
      4'd0: begin
        model_resp = 2'd0;
        model_data = 32'd0;
      end
      4'd1: begin
        model_resp = add_full[32] ? 2'd2 : 2'd1;
        model_data = add_full[31:0];
      end
      4'd2: begin
        model_resp = (job_op2 > job_op1) ? 2'd2 : 2'd1;
        model_data = job_op1 - job_op2;
      end
      4'd5: begin
        model_resp = 2'd1;
        model_data = job_op1 << job_op2[4:0];
      end
      4'd6: begin
        model_resp = 2'd1;
        model_data = job_op1 >> job_op2[4:0];
      end
      default: begin
        model_resp = 2'd3;
        model_data = 32'd0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; a response on the final WAIT cycle takes the normal path.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (job_valid) state_d = StCmd;
      StCmd:   state_d = StOpnd2;
      StOpnd2: state_d = (cmd_q == 4'd0) ? StDone : StWait;
      StWait:  if (resp_seen || wait_hit) state_d = StDone;
      StDone:  if (done_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Decoded outputs of the FSM.
  always_comb begin
    job_ready    = 1'b0;
    done_valid   = 1'b0;
    req_cmd_out  = 4'd0;
    req_data_out = 32'd0;
    unique case (state_q)
      StIdle:  job_ready = 1'b1;
      StCmd: begin
        req_cmd_out  = cmd_q;
        req_data_out = op1_q;
      end
      StOpnd2: req_data_out = op2_q;
      StDone:  done_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: job latch, wait counter, result capture, error bookkeeping.
  always_comb begin
    cmd_d      = cmd_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    exp_resp_d = exp_resp_q;
    exp_data_d = exp_data_q;
    wait_cnt_d = wait_cnt_q;
    resp_d     = resp_q;
    data_d     = data_q;
    timeout_d  = timeout_q;
    mismatch_d = mismatch_q;
    proto_d    = proto_q;
    err_d      = err_q;

    if (accept) begin
      cmd_d      = job_cmd;
      op1_d      = job_op1;
      op2_d      = job_op2;
      exp_resp_d = model_resp;
      exp_data_d = model_data;
    end

    if (state_q == StOpnd2) wait_cnt_d = 16'd0;

    if (state_q == StWait) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
      if (resp_seen) begin
        resp_d     = out_resp;
        data_d     = out_data;
        mismatch_d = (out_resp != exp_resp_q) ||
                     ((out_resp == 2'd1) && (out_data != exp_data_q));
      end else if (wait_hit) begin
        timeout_d = 1'b1;
      end
    end

    if (release_done) begin
      if ((timeout_q || mismatch_q) && !(&err_q)) err_d = err_q + 1'b1;
      resp_d     = 2'd0;
      data_d     = 32'd0;
      timeout_d  = 1'b0;
      mismatch_d = 1'b0;
    end

    // Responses outside WAIT are illegal for a single-outstanding port.
    if (resp_seen && (state_q != StWait)) proto_d = 1'b1;
  end

  // Datapath registers.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      cmd_q      <= 4'd0;
      op1_q      <= 32'd0;
      op2_q      <= 32'd0;
      exp_resp_q <= 2'd0;
      exp_data_q <= 32'd0;
      wait_cnt_q <= 16'd0;
      resp_q     <= 2'd0;
      data_q     <= 32'd0;
      timeout_q  <= 1'b0;
      mismatch_q <= 1'b0;
      proto_q    <= 1'b0;
      err_q      <= '0;
    end else begin
      cmd_q      <= cmd_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      exp_resp_q <= exp_resp_d;
      exp_data_q <= exp_data_d;
      wait_cnt_q <= wait_cnt_d;
      resp_q     <= resp_d;
      data_q     <= data_d;
      timeout_q  <= timeout_d;
      mismatch_q <= mismatch_d;
      proto_q    <= proto_d;
      err_q      <= err_d;
    end
  end

  assign done_resp     = resp_q;
  assign done_data     = data_q;
  assign done_timeout  = timeout_q;
  assign done_mismatch = mismatch_q;
  assign protocol_err  = proto_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_calc1_port_driver.sv
// Bench for calc1_port_driver: directed jobs with hand-computed expectations pushed into a
// scoreboard queue; an independent monitor pops and compares on each done handshake.
module tb_calc1_port_driver;

  localparam int unsigned TO = 4;

  logic        c_clk;
  logic        reset;
  logic        job_valid;
  logic        job_ready;
  logic [3:0]  job_cmd;
  logic [31:0] job_op1;
  logic [31:0] job_op2;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic        done_valid;
  logic        done_ready;
  logic [1:0]  done_resp;
  logic [31:0] done_data;
  logic        done_timeout;
  logic        done_mismatch;
  logic        protocol_err;
  logic [15:0] err_count;

  calc1_port_driver #(
    .TIMEOUT   (TO),
    .ERR_CNT_W (16)
  ) dut (
    .c_clk         (c_clk),
    .reset         (reset),
    .job_valid     (job_valid),
    .job_ready     (job_ready),
    .job_cmd       (job_cmd),
    .job_op1       (job_op1),
    .job_op2       (job_op2),
    .req_cmd_out   (req_cmd_out),
    .req_data_out  (req_data_out),
    .out_resp      (out_resp),
    .out_data      (out_data),
    .done_valid    (done_valid),
    .done_ready    (done_ready),
    .done_resp     (done_resp),
    .done_data     (done_data),
    .done_timeout  (done_timeout),
    .done_mismatch (done_mismatch),
    .protocol_err  (protocol_err),
    .err_count     (err_count)
  );

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    logic        to;
    logic        mm;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] exp_err = 16'd0;

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!job_ready && n < 100) begin
      @(negedge c_clk);
      n++;
    end
    chk("job_ready_wait", job_ready, 1);
  endtask

  // Issue one job and play the calc1 side; expectations go to the scoreboard.
  task automatic run_job(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                         input bit give, input logic [1:0] rr, input logic [31:0] rd,
                         input int delay, input logic [1:0] er, input logic [31:0] ed,
                         input bit eto, input bit emm, input bit stall);
    exp_t e;
    wait_idle();
    e.resp = er; e.data = ed; e.to = eto; e.mm = emm;
    sb_q.push_back(e);
    if ((eto || emm) && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
    if (stall) done_ready = 1'b0;
    job_valid = 1'b1; job_cmd = cmd; job_op1 = op1; job_op2 = op2;
    @(negedge c_clk);
    job_valid = 1'b0;
    chk("cmd_phase_cmd", req_cmd_out, cmd);
    chk("cmd_phase_data", req_data_out, op1);
    @(negedge c_clk);
    chk("opnd2_phase_cmd", req_cmd_out, 0);
    chk("opnd2_phase_data", req_data_out, op2);
    @(negedge c_clk);
    if (cmd == 4'd0) begin
      chk("noop_direct_done", done_valid, 1);
    end else if (give) begin
      repeat (delay - 1) @(negedge c_clk);
      chk("wait_req_cmd_zero", req_cmd_out, 0);
      out_resp = rr; out_data = rd;
      @(negedge c_clk);
      out_resp = 2'd0; out_data = 32'd0;
      chk("resp_to_done", done_valid, 1);
    end else begin
      for (int i = 0; i < TO; i++) begin
        chk("wait_no_done", done_valid, 0);
        @(negedge c_clk);
      end
      chk("timeout_done", done_valid, 1);
    end
    if (stall) begin
      for (int i = 0; i < 10; i++) begin
        chk("stall_valid", done_valid, 1);
        chk("stall_timeout", done_timeout, eto);
        chk("stall_resp", done_resp, er);
        chk("stall_data", done_data, ed);
        @(negedge c_clk);
      end
      done_ready = 1'b1;
    end
    wait_idle();
    chk("err_count", err_count, exp_err);
  endtask

  // Monitor: compare against the scoreboard head on every done handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge c_clk);
      #1;
      if (reset && done_valid && done_ready) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done_valid=1, expected no result at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk("done_resp", done_resp, e.resp);
          chk("done_data", done_data, e.data);
          chk("done_timeout", done_timeout, e.to);
          chk("done_mismatch", done_mismatch, e.mm);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; job_valid = 1'b0; job_cmd = 4'd0; job_op1 = 32'd0; job_op2 = 32'd0;
    out_resp = 2'd0; out_data = 32'd0; done_ready = 1'b1;
    #1;
    chk("rst_job_ready", job_ready, 1);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_req_cmd", req_cmd_out, 0);
    chk("rst_req_data", req_data_out, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_protocol_err", protocol_err, 0);
    @(negedge c_clk);
    @(negedge c_clk);
    reset = 1'b1;
    @(negedge c_clk);

    //       cmd   op1           op2           give rr    rd            dly er    ed            to mm st
    run_job(4'd1, 32'h1,        32'h2,        1, 2'd1, 32'h3,        3, 2'd1, 32'h3,        0, 0, 0);
    run_job(4'd1, 32'hFFFFFFFF, 32'h1,        1, 2'd2, 32'h0,        1, 2'd2, 32'h0,        0, 0, 0);
    run_job(4'd1, 32'hFFFFFFFF, 32'h1,        1, 2'd1, 32'h0,        1, 2'd1, 32'h0,        0, 1, 0);
    run_job(4'd2, 32'h5,        32'h7,        1, 2'd2, 32'hFFFFFFFE, 2, 2'd2, 32'hFFFFFFFE, 0, 0, 0);
    run_job(4'd5, 32'h1,        32'h21,       1, 2'd1, 32'h2,        1, 2'd1, 32'h2,        0, 0, 0);
    run_job(4'd6, 32'h80,       32'h3,        1, 2'd1, 32'h11,       1, 2'd1, 32'h11,       0, 1, 0);
    run_job(4'hF, 32'h9,        32'h9,        1, 2'd3, 32'h0,        1, 2'd3, 32'h0,        0, 0, 0);
    run_job(4'd0, 32'h1234,     32'h5678,     0, 2'd0, 32'h0,        1, 2'd0, 32'h0,        0, 0, 0);
    // Response on the final WAIT cycle beats the timeout.
    run_job(4'd1, 32'h10,       32'h20,       1, 2'd1, 32'h30,       4, 2'd1, 32'h30,       0, 0, 0);
    run_job(4'd1, 32'h1,        32'h1,        0, 2'd0, 32'h0,        1, 2'd0, 32'h0,        1, 0, 1);

    // Stray response while idle sets the sticky flag.
    wait_idle();
    chk("proto_before", protocol_err, 0);
    out_resp = 2'd1; out_data = 32'hDEAD;
    @(negedge c_clk);
    out_resp = 2'd0; out_data = 32'd0;
    chk("proto_set", protocol_err, 1);
    chk("proto_no_done", done_valid, 0);
    run_job(4'd1, 32'h2,        32'h3,        1, 2'd1, 32'h5,        1, 2'd1, 32'h5,        0, 0, 0);
    chk("proto_sticky", protocol_err, 1);

    // Reset in the middle of WAIT drops the job.
    wait_idle();
    job_valid = 1'b1; job_cmd = 4'd1; job_op1 = 32'h7; job_op2 = 32'h8;
    @(negedge c_clk);
    job_valid = 1'b0;
    @(negedge c_clk);
    @(negedge c_clk);
    chk("pre_rst_in_wait", job_ready, 0);
    reset = 1'b0;
    #1;
    chk("wrst_job_ready", job_ready, 1);
    chk("wrst_done_valid", done_valid, 0);
    chk("wrst_req_cmd", req_cmd_out, 0);
    chk("wrst_req_data", req_data_out, 0);
    chk("wrst_protocol_err", protocol_err, 0);
    chk("wrst_err_count", err_count, 0);
    chk("wrst_done_timeout", done_timeout, 0);
    @(negedge c_clk);
    reset = 1'b1;
    repeat (6) @(negedge c_clk);
    chk("post_rst_idle", job_ready, 1);
    chk("post_rst_no_done", done_valid, 0);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
